truth_table_checker: RTL and testbench

Sequential stimulus/response checker that sits around a combinational gate under test, such as the NAND-built AND gate.
- Upstream: drives every input combination onto the gate inputs.
- Downstream: samples the gate output after a settle delay and compares it against a parameterised expected truth table.
- Reports pass/fail, mismatch count and first failing row.
- Used for self-checking gate-level tests in the simulator.

---
 rtl/truth_table_checker_pkg.sv | 27 ++
 rtl/truth_table_checker_settle_timer.sv | 28 ++
 rtl/truth_table_checker.sv | 145 ++++++++++++++
 tb/tb_truth_table_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared types and sizing helpers for the truth-table checker.
// Sizes are functions of the input count so that every file derives them the same way.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_t;

    // Number of truth-table rows (ROWS) for a gate with nIn inputs.
    function automatic int ttRows(input int nIn);
        return 1 << nIn;
    endfunction

    // Mismatch counter width (FCW): it must hold ttRows(nIn) without wrapping.
    function automatic int ttFcw(input int nIn);
        return nIn + 1;
    endfunction

    // Settle timer width; kept at least one bit so a zero-settle build still elaborates.
    function automatic int ttTimerWidth(input int settleCycles);
        return (settleCycles > 0) ? $clog2(settleCycles + 1) : 1;
    endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Loading settleCycles-1 therefore gives a hold of exactly settleCycles cycles.
module settle_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] loadValue,
    output logic             tc
);

    logic [WIDTH-1:0] countReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= loadValue;
        end else if (en && (countReg != '0)) begin
            countReg <= countReg - WIDTH'(1);
        end
    end

    assign tc = (countReg == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input combination of a gate under test, samples its output after a settle
// delay and compares against EXPECT, reporting pass, mismatch count and first failing row.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                         N_IN          = 2,
    parameter int                         SETTLE_CYCLES = 1,
    parameter logic [ttRows(N_IN)-1:0]    EXPECT        = 4'b1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     inY,
    output logic [N_IN-1:0]          drv,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ttFcw(N_IN)-1:0]   fail_count,
    output logic                     first_fail_valid,
    output logic [N_IN-1:0]          first_fail_row
);

    localparam int                ROWS        = ttRows(N_IN);
    localparam int                FCW         = ttFcw(N_IN);
    localparam int                TW          = ttTimerWidth(SETTLE_CYCLES);
    localparam logic [TW-1:0]     SETTLE_LOAD = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [N_IN-1:0]   LAST_ROW    = N_IN'(ROWS - 1);

    tt_state_t          stateReg;
    tt_state_t          stateNext;
    logic [N_IN-1:0]    rowReg;
    logic [FCW-1:0]     failCountReg;
    logic               firstFailValidReg;
    logic [N_IN-1:0]    firstFailRowReg;
    logic               passReg;

    logic               timerLoad;
    logic               timerEn;
    logic               timerTc;
    logic               startAccept;
    logic               sampleNow;
    logic               lastRow;
    logic               mismatch;

    assign lastRow  = (rowReg == LAST_ROW);
    assign mismatch = (inY != EXPECT[rowReg]);
    assign timerEn  = (stateReg == SETTLE);

    settle_timer #(
        .WIDTH (TW)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timerLoad),
        .en        (timerEn),
        .loadValue (SETTLE_LOAD),
        .tc        (timerTc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // A zero settle time skips SETTLE entirely, so every row is a single SAMPLE cycle.
    always_comb begin
        stateNext   = stateReg;
        timerLoad   = 1'b0;
        startAccept = 1'b0;
        sampleNow   = 1'b0;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    startAccept = 1'b1;
                    timerLoad   = 1'b1;
                    stateNext   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (timerTc) begin
                    stateNext = SAMPLE;
                end
            end
            SAMPLE: begin
                sampleNow = 1'b1;
                if (lastRow) begin
                    stateNext = DONE;
                end else begin
                    timerLoad = 1'b1;
                    stateNext = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // pass is resolved on the final SAMPLE edge, folding in that row's own mismatch,
    // so it is already valid during the DONE pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowReg            <= '0;
            failCountReg      <= '0;
            firstFailValidReg <= 1'b0;
            firstFailRowReg   <= '0;
            passReg           <= 1'b0;
        end else if (startAccept) begin
            rowReg            <= '0;
            failCountReg      <= '0;
            firstFailValidReg <= 1'b0;
            firstFailRowReg   <= '0;
            passReg           <= 1'b0;
        end else if (sampleNow) begin
            if (!lastRow) begin
                rowReg <= rowReg + N_IN'(1);
            end
            if (mismatch) begin
                failCountReg <= failCountReg + FCW'(1);
                if (!firstFailValidReg) begin
                    firstFailValidReg <= 1'b1;
                    firstFailRowReg   <= rowReg;
                end
            end
            if (lastRow) begin
                passReg <= (failCountReg == '0) && !mismatch;
            end
        end
    end

    assign busy             = (stateReg == SETTLE) || (stateReg == SAMPLE);
    assign done             = (stateReg == DONE);
    assign drv              = busy ? rowReg : '0;
    assign pass             = passReg;
    assign fail_count       = failCountReg;
    assign first_fail_valid = firstFailValidReg;
    assign first_fail_row   = firstFailRowReg;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (settle 1, 0, 3) checked every cycle
// against a timeline model, plus hand-computed expectations for latency and results.
module tb_truth_table_checker;

    logic       clk;
    logic       rst_n;
    logic [2:0] startW;
    logic       inYW     [3];
    logic [1:0] drvW     [3];
    logic       busyW    [3];
    logic       doneW    [3];
    logic       passW    [3];
    logic [2:0] fcW      [3];
    logic       ffvW     [3];
    logic [1:0] ffrW     [3];

    int mode0;   // 0 = correct AND gate, 1 = stuck-at-0, 2 = stuck-at-1
    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign inYW[0] = (mode0 == 0) ? (drvW[0] == 2'b11) : (mode0 == 2);
    assign inYW[1] = (drvW[1] == 2'b11);
    assign inYW[2] = (drvW[2] == 2'b11);

    truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECT(4'b1000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(startW[0]), .inY(inYW[0]), .drv(drvW[0]),
        .busy(busyW[0]), .done(doneW[0]), .pass(passW[0]), .fail_count(fcW[0]),
        .first_fail_valid(ffvW[0]), .first_fail_row(ffrW[0]));

    truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(0), .EXPECT(4'b1000)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(startW[1]), .inY(inYW[1]), .drv(drvW[1]),
        .busy(busyW[1]), .done(doneW[1]), .pass(passW[1]), .fail_count(fcW[1]),
        .first_fail_valid(ffvW[1]), .first_fail_row(ffrW[1]));

    truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(3), .EXPECT(4'b1000)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(startW[2]), .inY(inYW[2]), .drv(drvW[2]),
        .busy(busyW[2]), .done(doneW[2]), .pass(passW[2]), .fail_count(fcW[2]),
        .first_fail_valid(ffvW[2]), .first_fail_row(ffrW[2]));

    typedef struct packed {
        logic [1:0] drv;
        logic       busy;
        logic       done;
        logic [2:0] fc;
        logic       ffv;
        logic [1:0] ffr;
        logic       pass;
    } expT;

    function automatic int scOf(input int i);
        return (i == 1) ? 0 : ((i == 2) ? 3 : 1);
    endfunction

    function automatic int modeOf(input int i);
        return (i == 0) ? mode0 : 0;
    endfunction

    function automatic bit gateOut(input int mode, input int row);
        return (mode == 0) ? (row == 3) : (mode == 2);
    endfunction

    // Expected outputs k cycles after the accepting edge: each row takes sc+1 cycles,
    // a row's verdict shows once its last cycle has ended, done follows the last row.
    function automatic expT modelAt(input int mode, input int sc, input int k);
        expT e;
        int per, last, cnt, first;
        per   = sc + 1;
        last  = 4 * per;
        e     = '0;
        cnt   = 0;
        first = -1;
        if (k >= 1 && k <= last) begin
            e.busy = 1'b1;
            e.drv  = 2'((k - 1) / per);
        end
        e.done = (k == last + 1);
        for (int r = 0; r < 4; r++) begin
            if (((r + 1) * per < k) && (gateOut(mode, r) != (r == 3))) begin
                cnt++;
                if (first < 0) first = r;
            end
        end
        e.fc   = 3'(cnt);
        e.ffv  = (first >= 0);
        e.ffr  = (first >= 0) ? 2'(first) : 2'd0;
        e.pass = (k == last + 1) && (cnt == 0);
        return e;
    endfunction

    int  kCnt [3];
    expT held [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                kCnt[i] = 0;
                held[i] = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (kCnt[i] == 0) begin
                    if (startW[i]) begin
                        kCnt[i] = 1;
                        held[i] = '0;
                    end
                end else if (kCnt[i] == 4 * (scOf(i) + 1) + 1) begin
                    held[i]      = modelAt(modeOf(i), scOf(i), kCnt[i]);
                    held[i].done = 1'b0;
                    kCnt[i]      = 0;
                end else begin
                    kCnt[i]++;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", name, inst, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            expT e;
            e = (kCnt[i] == 0) ? held[i] : modelAt(modeOf(i), scOf(i), kCnt[i]);
            chk("cyc_drv",  i, int'(drvW[i]),  int'(e.drv));
            chk("cyc_busy", i, int'(busyW[i]), int'(e.busy));
            chk("cyc_done", i, int'(doneW[i]), int'(e.done));
            chk("cyc_fc",   i, int'(fcW[i]),   int'(e.fc));
            chk("cyc_ffv",  i, int'(ffvW[i]),  int'(e.ffv));
            chk("cyc_ffr",  i, int'(ffrW[i]),  int'(e.ffr));
            chk("cyc_pass", i, int'(passW[i]), int'(e.pass));
        end
    end

    task automatic runTest(input string tag, input int inst, input int mode, input int expLat,
                           input int expFc, input int expFfv, input int expFfr, input int expPass,
                           input int rePulseAt, input int resetAt, input int checkSeq);
        int n;
        int doneAt;
        int seq [9];
        int expSeq [9];
        expSeq = '{0, 0, 0, 1, 1, 2, 2, 3, 3};
        if (inst == 0) mode0 = mode;
        @(negedge clk);
        startW[inst] = 1'b1;
        n      = 0;
        doneAt = -1;
        while (n < 40 && doneAt < 0) begin
            @(negedge clk);
            n++;
            startW[inst] = (n == rePulseAt);
            if (n <= 8) seq[n] = int'(drvW[inst]);
            if (n == 1) begin
                chk({tag, "_clr_fc"},   inst, int'(fcW[inst]),   0);
                chk({tag, "_clr_ffv"},  inst, int'(ffvW[inst]),  0);
                chk({tag, "_clr_pass"}, inst, int'(passW[inst]), 0);
            end
            if (n == resetAt) begin
                chk({tag, "_pre_rst_fc"},  inst, int'(fcW[inst]),  2);
                chk({tag, "_pre_rst_drv"}, inst, int'(drvW[inst]), 2);
                #2 rst_n = 1'b0;
                #1;
                chk({tag, "_rst_busy"}, inst, int'(busyW[inst]), 0);
                chk({tag, "_rst_drv"},  inst, int'(drvW[inst]),  0);
                chk({tag, "_rst_fc"},   inst, int'(fcW[inst]),   0);
                chk({tag, "_rst_ffv"},  inst, int'(ffvW[inst]),  0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            if (doneW[inst]) doneAt = n;
        end
        if (resetAt > 0) begin
            chk({tag, "_no_done"}, inst, doneAt, -1);
        end else begin
            chk({tag, "_latency"}, inst, doneAt, expLat);
            chk({tag, "_fc"},      inst, int'(fcW[inst]),   expFc);
            chk({tag, "_ffv"},     inst, int'(ffvW[inst]),  expFfv);
            chk({tag, "_ffr"},     inst, int'(ffrW[inst]),  expFfr);
            chk({tag, "_pass"},    inst, int'(passW[inst]), expPass);
        end
        if (checkSeq != 0) begin
            for (int j = 1; j <= 8; j++) chk({tag, "_drv_seq"}, inst, seq[j], expSeq[j]);
        end
        @(negedge clk);
        startW[inst] = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_idle_busy"}, inst, int'(busyW[inst]), 0);
        $display("run %s inst%0d done_at=%0d fail_count=%0d first_fail_row=%0d pass=%0d",
                 tag, inst, doneAt, fcW[inst], ffrW[inst], passW[inst]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        mode0  = 0;
        rst_n  = 1'b0;
        startW = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_busy", 0, int'(busyW[0]), 0);
        chk("reset_drv",  0, int'(drvW[0]),  0);
        chk("reset_fc",   0, int'(fcW[0]),   0);
        chk("reset_pass", 0, int'(passW[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        //          tag              inst mode lat fc ffv ffr pass rep rst seq
        runTest("and_default",     0,  0,   9,  0, 0,  0,  1,   0,  0,  1);
        runTest("stuck0",          0,  1,   9,  1, 1,  3,  0,   0,  0,  0);
        runTest("stuck1",          0,  2,   9,  3, 1,  0,  0,   0,  0,  0);
        runTest("restart_repulse", 0,  0,   9,  0, 0,  0,  1,   4,  0,  1);
        runTest("start_in_done",   0,  2,   9,  3, 1,  0,  0,   9,  0,  0);
        runTest("reset_mid",       0,  2,   0,  0, 0,  0,  0,   0,  5,  0);
        runTest("after_reset",     0,  0,   9,  0, 0,  0,  1,   0,  0,  1);
        runTest("settle0",         1,  0,   5,  0, 0,  0,  1,   0,  0,  0);
        runTest("settle3",         2,  0,  17,  0, 0,  0,  1,   0,  0,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
